// File: rtl/return_address_stack_if.sv
// Fetch-side bundle for the return address stack: call/return requests,
// flush checkpoint restore, and the prediction/checkpoint read-out.
interface return_address_stack_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic             push;
  logic [XLEN-1:0]  push_addr;
  logic             pop;
  logic             recover;
  logic [PTR_W-1:0] rec_tos;
  logic [PTR_W:0]   rec_count;
  logic [XLEN-1:0]  rec_top;

  logic [XLEN-1:0]  ras_top;
  logic             ras_valid;
  logic [PTR_W-1:0] cur_tos;
  logic [PTR_W:0]   cur_count;

  modport master (
    output push, push_addr, pop, recover, rec_tos, rec_count, rec_top,
    input  ras_top, ras_valid, cur_tos, cur_count
  );

  modport slave (
    input  push, push_addr, pop, recover, rec_tos, rec_count, rec_top,
    output ras_top, ras_valid, cur_tos, cur_count
  );
endinterface

// File: rtl/return_address_stack.sv
// Circular return address stack with overwrite-on-full, call/return
// replacement and single-entry checkpoint repair on pipeline flush.
module return_address_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input logic                    CLK,
  input logic                    reset,
  return_address_stack_if.slave  ras
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(RAS_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] TOS_INIT = PTR_W'(RAS_DEPTH - 1);

  logic [XLEN-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_tos;
  logic [PTR_W:0]   r_count;

  logic [PTR_W-1:0] w_tos_inc;
  logic [PTR_W-1:0] w_tos_dec;
  logic [PTR_W:0]   w_rec_count;
  logic [PTR_W-1:0] w_tos_nxt;
  logic [PTR_W:0]   w_count_nxt;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;
  logic [XLEN-1:0]  w_wr_data;

  assign w_tos_inc   = r_tos + 1'b1;
  assign w_tos_dec   = r_tos - 1'b1;
  assign w_rec_count = (ras.rec_count > CNT_FULL) ? CNT_FULL : ras.rec_count;

  // Priority: recover, then call+return replacement, then push, then pop.
  always_comb begin
    w_tos_nxt   = r_tos;
    w_count_nxt = r_count;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_tos;
    w_wr_data   = ras.push_addr;
    if (ras.recover) begin
      w_tos_nxt   = ras.rec_tos;
      w_count_nxt = w_rec_count;
      w_wr_en     = 1'b1;
      w_wr_idx    = ras.rec_tos;
      w_wr_data   = ras.rec_top;
    end else if (ras.push && ras.pop) begin
      w_wr_en  = 1'b1;
      w_wr_idx = r_tos;
      if (r_count == '0) begin
        w_count_nxt = CNT_ONE;
      end
    end else if (ras.push) begin
      w_tos_nxt = w_tos_inc;
      w_wr_en   = 1'b1;
      w_wr_idx  = w_tos_inc;
      // Full stack: the oldest entry is overwritten, occupancy saturates.
      w_count_nxt = (r_count == CNT_FULL) ? CNT_FULL : r_count + 1'b1;
    end else if (ras.pop && (r_count != '0)) begin
      w_tos_nxt   = w_tos_dec;
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_tos   <= TOS_INIT;
      r_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_tos   <= w_tos_nxt;
      r_count <= w_count_nxt;
      if (w_wr_en) begin
        r_mem[w_wr_idx] <= w_wr_data;
      end
    end
  end

  assign ras.ras_top   = r_mem[r_tos];
  assign ras.ras_valid = (r_count != '0);
  assign ras.cur_tos   = r_tos;
  assign ras.cur_count = r_count;
endmodule
